// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port SRAM between an instruction-fetch port (read only)
//   and a data port (read/write). One access runs at a time:
//     IDLE   -> pick a requester, latch its address, write data and direction
//     ACCESS -> drive the SRAM for WAIT_CYCLES cycles; on the last cycle a read
//               captures sram_rdata into the granted port's rdata register
//     DONE   -> one-cycle ready pulse to the granted port, then back to IDLE
//   mem_rd and mem_wr together are treated as a write.
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN - when defined, contested requests go to the port that was
//                        not served by the previous access (data wins first after
//                        reset). When undefined, data always beats fetch.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   if_req, if_addr      fetch request and address
//   if_rdata, if_ready   registered fetched word, one-cycle completion pulse
//   mem_rd, mem_wr       data read / write requests
//   mem_addr, mem_wdata  data address and write data
//   mem_rdata, mem_ready registered read word, one-cycle completion pulse
//   sram_*               shared single-port SRAM (addr, wdata, we, oe, rdata)
//   busy                 high whenever an access is in progress (not IDLE)
module mem_port_arbiter #(
    parameter int WAIT_CYCLES = 3  // SRAM access duration, legal range 1..15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    output logic        sram_we,
    output logic        sram_oe,
    input  logic [31:0] sram_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_t;

    localparam logic [3:0] LP_CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;          // remaining ACCESS cycles after the current one
    logic        r_grant_mem;    // 1: data port owns the access, 0: fetch port
    logic        r_is_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_if_rdata;
    logic [31:0] r_mem_rdata;

    logic        w_mem_req;
    logic        w_any_req;
    logic        w_grant_mem;
    logic        w_start;
    logic        w_last_access;

    assign w_mem_req     = mem_rd | mem_wr;
    assign w_any_req     = if_req | w_mem_req;
    assign w_start       = (r_state == ST_IDLE) && w_any_req;
    assign w_last_access = (r_state == ST_ACCESS) && (r_cnt == 4'd0);

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_mem;  // port served by the previous access; reset = fetch

    // Uncontested requests win outright; a contested one goes to the port
    // that did not get the previous access.
    assign w_grant_mem = w_mem_req && (!if_req || !r_last_mem);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_mem <= 1'b0;
        end else if (w_start) begin
            r_last_mem <= w_grant_mem;
        end
    end
`else
    assign w_grant_mem = w_mem_req;
`endif

    // State register
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_any_req) w_next_state = ST_ACCESS;
            ST_ACCESS: if (r_cnt == 4'd0) w_next_state = ST_DONE;
            ST_DONE:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        sram_oe   = 1'b0;
        sram_we   = 1'b0;
        if_ready  = 1'b0;
        mem_ready = 1'b0;
        busy      = (r_state != ST_IDLE);
        case (r_state)
            ST_ACCESS: begin
                sram_oe = !r_is_write;
                sram_we = r_is_write;
            end
            ST_DONE: begin
                mem_ready = r_grant_mem;
                if_ready  = !r_grant_mem;
            end
            default: ;
        endcase
    end

    // Access datapath: operands are latched at grant so requester inputs may
    // change or drop during ACCESS without disturbing the SRAM cycle.
    // NOTE: the latched operands and read-data registers are explicitly cleared
    // on reset so the SRAM bus and rdata outputs come up at a known 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= 4'd0;
            r_grant_mem <= 1'b0;
            r_is_write  <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_if_rdata  <= 32'd0;
            r_mem_rdata <= 32'd0;
        end else begin
            if (w_start) begin
                r_cnt       <= LP_CNT_LOAD;
                r_grant_mem <= w_grant_mem;
                r_is_write  <= w_grant_mem & mem_wr;
                r_addr      <= w_grant_mem ? mem_addr : if_addr;
                r_wdata     <= mem_wdata;
            end else if ((r_state == ST_ACCESS) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_last_access && !r_is_write) begin
                if (r_grant_mem) begin
                    r_mem_rdata <= sram_rdata;
                end else begin
                    r_if_rdata <= sram_rdata;
                end
            end
        end
    end

    assign sram_addr  = r_addr;
    assign sram_wdata = r_wdata;
    assign if_rdata   = r_if_rdata;
    assign mem_rdata  = r_mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Checks mem_port_arbiter (WAIT_CYCLES=3) against a transaction-level model
//   that counts the cycles elapsed since a grant, plus hand-computed scenarios
//   for a single fetch, a single write, contested requests, reset mid-access
//   and a second instance built with WAIT_CYCLES=1.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int W = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, mem_rd, mem_wr;
    logic [31:0] if_addr, mem_addr, mem_wdata, sram_rdata;
    logic [31:0] if_rdata, mem_rdata, sram_addr, sram_wdata;
    logic        if_ready, mem_ready, sram_we, sram_oe, busy;

    // second instance, WAIT_CYCLES=1
    logic        if_req_1, mem_rd_1, mem_wr_1;
    logic [31:0] if_addr_1, mem_addr_1, mem_wdata_1, sram_rdata_1;
    logic [31:0] if_rdata_1, mem_rdata_1, sram_addr_1, sram_wdata_1;
    logic        if_ready_1, mem_ready_1, sram_we_1, sram_oe_1, busy_1;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WAIT_CYCLES(W)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_we(sram_we),
        .sram_oe(sram_oe), .sram_rdata(sram_rdata), .busy(busy)
    );

    mem_port_arbiter #(.WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req_1), .if_addr(if_addr_1), .if_rdata(if_rdata_1), .if_ready(if_ready_1),
        .mem_rd(mem_rd_1), .mem_wr(mem_wr_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
        .mem_rdata(mem_rdata_1), .mem_ready(mem_ready_1),
        .sram_addr(sram_addr_1), .sram_wdata(sram_wdata_1), .sram_we(sram_we_1),
        .sram_oe(sram_oe_1), .sram_rdata(sram_rdata_1), .busy(busy_1)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkb(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_phase: 0 = no access, 1..W = k-th SRAM cycle, W+1 = completion cycle.
    int          m_phase     = 0;
    logic        m_gmem      = 1'b0;
    logic        m_write     = 1'b0;
    logic        m_last_mem  = 1'b0;
    logic [31:0] m_addr      = '0;
    logic [31:0] m_wdata     = '0;
    logic [31:0] m_if_rdata  = '0;
    logic [31:0] m_mem_rdata = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase     = 0;
            m_last_mem  = 1'b0;
            m_addr      = '0;
            m_wdata     = '0;
            m_if_rdata  = '0;
            m_mem_rdata = '0;
        end else if (m_phase == 0) begin
            if (if_req || mem_rd || mem_wr) begin
                if (!(mem_rd || mem_wr)) begin
                    m_gmem = 1'b0;
                end else if (!if_req) begin
                    m_gmem = 1'b1;
                end else begin
`ifdef ARB_ROUND_ROBIN_EN
                    m_gmem = !m_last_mem;
`else
                    m_gmem = 1'b1;
`endif
                end
                m_last_mem = m_gmem;
                m_write    = m_gmem && mem_wr;
                m_addr     = m_gmem ? mem_addr : if_addr;
                m_wdata    = mem_wdata;
                m_phase    = 1;
            end
        end else if (m_phase <= W) begin
            if (m_phase == W && !m_write) begin
                if (m_gmem) m_mem_rdata = sram_rdata;
                else        m_if_rdata  = sram_rdata;
            end
            m_phase++;
        end else begin
            m_phase = 0;
        end
    end

    // ---------------- cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            checkb("m_busy",      busy,      m_phase != 0);
            checkb("m_sram_oe",   sram_oe,   (m_phase >= 1) && (m_phase <= W) && !m_write);
            checkb("m_sram_we",   sram_we,   (m_phase >= 1) && (m_phase <= W) && m_write);
            checkb("m_if_ready",  if_ready,  (m_phase == W + 1) && !m_gmem);
            checkb("m_mem_ready", mem_ready, (m_phase == W + 1) && m_gmem);
            check("m_if_rdata",   if_rdata,  m_if_rdata);
            check("m_mem_rdata",  mem_rdata, m_mem_rdata);
            if (m_phase >= 1 && m_phase <= W) begin
                check("m_sram_addr", sram_addr, m_addr);
                if (m_write) check("m_sram_wdata", sram_wdata, m_wdata);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not end by t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    int seq[3];
    int nseq;

    initial begin
        rst = 1'b1;
        if_req = 0; mem_rd = 0; mem_wr = 0;
        if_addr = 0; mem_addr = 0; mem_wdata = 0; sram_rdata = 0;
        if_req_1 = 0; mem_rd_1 = 0; mem_wr_1 = 0;
        if_addr_1 = 0; mem_addr_1 = 0; mem_wdata_1 = 0; sram_rdata_1 = 32'h77;

        repeat (2) @(posedge clk);
        #2;
        chk_en = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        checkb("rst_busy", busy, 1'b0);
        checkb("rst_oe", sram_oe, 1'b0);
        checkb("rst_we", sram_we, 1'b0);
        checkb("rst_if_ready", if_ready, 1'b0);
        checkb("rst_mem_ready", mem_ready, 1'b0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_mem_rdata", mem_rdata, 32'h0);
        check("rst_sram_addr", sram_addr, 32'h0);
        check("rst_sram_wdata", sram_wdata, 32'h0);

        // single fetch
        step();
        if_req = 1; if_addr = 32'h10; sram_rdata = 32'hE3A01005;
        @(posedge clk);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            checkb("f_oe", sram_oe, 1'b1);
            checkb("f_we", sram_we, 1'b0);
            check("f_addr", sram_addr, 32'h10);
            checkb("f_ready_early", if_ready, 1'b0);
        end
        @(negedge clk);
        checkb("f_if_ready", if_ready, 1'b1);
        checkb("f_mem_ready", mem_ready, 1'b0);
        checkb("f_oe_done", sram_oe, 1'b0);
        check("f_if_rdata", if_rdata, 32'hE3A01005);
        check("f_mem_rdata", mem_rdata, 32'h0);
        check("f_model_rdata", m_if_rdata, 32'hE3A01005);

        // single write
        step();
        if_req = 0;
        mem_wr = 1; mem_addr = 32'h400; mem_wdata = 32'hDEADBEEF; sram_rdata = 32'h12345678;
        @(posedge clk);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            checkb("w_we", sram_we, 1'b1);
            checkb("w_oe", sram_oe, 1'b0);
            check("w_addr", sram_addr, 32'h400);
            check("w_wdata", sram_wdata, 32'hDEADBEEF);
        end
        @(negedge clk);
        checkb("w_mem_ready", mem_ready, 1'b1);
        checkb("w_if_ready", if_ready, 1'b0);
        checkb("w_we_done", sram_we, 1'b0);
        check("w_mem_rdata", mem_rdata, 32'h0);
        check("w_if_rdata_held", if_rdata, 32'hE3A01005);

        // reset during the second SRAM cycle of a write
        step();
        mem_addr = 32'h800; mem_wdata = 32'h55AA55AA;
        @(posedge clk);
        @(negedge clk);
        checkb("r_we_c1", sram_we, 1'b1);
        step();
        rst = 1; mem_wr = 0;
        @(posedge clk);
        @(negedge clk);
        checkb("r_we", sram_we, 1'b0);
        checkb("r_oe", sram_oe, 1'b0);
        checkb("r_busy", busy, 1'b0);
        checkb("r_mem_ready", mem_ready, 1'b0);
        check("r_if_rdata", if_rdata, 32'h0);
        check("r_mem_rdata", mem_rdata, 32'h0);
        step();
        rst = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkb("r_no_ready", mem_ready, 1'b0);
        end

        // contested fetch + data read held continuously
        step();
        if_req = 1; if_addr = 32'h20;
        mem_rd = 1; mem_addr = 32'h30; sram_rdata = 32'h0BADF00D;
        nseq = 0;
        for (int c = 0; c < 40 && nseq < 3; c++) begin
            @(negedge clk);
            if (mem_ready) begin seq[nseq] = 1; nseq++; end
            else if (if_ready) begin seq[nseq] = 2; nseq++; end
        end
        step();
        if_req = 0; mem_rd = 0;
        check("c_grants", nseq, 3);
        check("c_grant0", seq[0], 1);
`ifdef ARB_ROUND_ROBIN_EN
        check("c_grant1", seq[1], 2);
`else
        check("c_grant1", seq[1], 1);
`endif
        check("c_grant2", seq[2], 1);

        // randomized traffic with occasional reset
        for (int c = 0; c < 2000; c++) begin
            step();
            rst        = ($urandom_range(0, 99) == 0);
            if_req     = ($urandom_range(0, 2) != 0);
            mem_rd     = ($urandom_range(0, 2) == 0);
            mem_wr     = ($urandom_range(0, 3) == 0);
            if_addr    = $urandom;
            mem_addr   = $urandom;
            mem_wdata  = $urandom;
            sram_rdata = $urandom;
        end
        step();
        rst = 0; if_req = 0; mem_rd = 0; mem_wr = 0;
        repeat (W + 3) @(posedge clk);

        // WAIT_CYCLES=1 instance, rd+wr together -> write
        step();
        mem_rd_1 = 1; mem_wr_1 = 1; mem_addr_1 = 32'h44; mem_wdata_1 = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        checkb("s_we", sram_we_1, 1'b1);
        checkb("s_oe", sram_oe_1, 1'b0);
        checkb("s_busy", busy_1, 1'b1);
        checkb("s_ready_early", mem_ready_1, 1'b0);
        check("s_addr", sram_addr_1, 32'h44);
        check("s_wdata", sram_wdata_1, 32'hCAFEF00D);
        @(negedge clk);
        checkb("s_mem_ready", mem_ready_1, 1'b1);
        checkb("s_if_ready", if_ready_1, 1'b0);
        checkb("s_we_done", sram_we_1, 1'b0);
        checkb("s_oe_done", sram_oe_1, 1'b0);
        check("s_mem_rdata", mem_rdata_1, 32'h0);
        check("s_if_rdata", if_rdata_1, 32'h0);
        step();
        mem_rd_1 = 0; mem_wr_1 = 0;
        @(negedge clk);
        checkb("s_ready_once", mem_ready_1, 1'b0);
        checkb("s_idle", busy_1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 3, SRAM access duration in cycles; legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port if_req, input, 1, instruction fetch read request.
REQ-005 The block SHALL have port if_addr, input, 32, fetch address.
REQ-006 The block SHALL have port if_rdata, output, 32, registered fetched word.
REQ-007 The block SHALL have port if_ready, output, 1, one-cycle fetch completion pulse.
REQ-008 The block SHALL have port mem_rd, input, 1, data read request.
REQ-009 The block SHALL have port mem_wr, input, 1, data write request.
REQ-010 The block SHALL have port mem_addr, input, 32, data address.
REQ-011 The block SHALL have port mem_wdata, input, 32, write data.
REQ-012 The block SHALL have port mem_rdata, output, 32, registered read word.
REQ-013 The block SHALL have port mem_ready, output, 1, one-cycle data completion pulse.
REQ-014 The block SHALL have ports sram_addr (out, 32), sram_wdata (out, 32), sram_we (out, 1), sram_oe (out, 1), sram_rdata (in, 32): shared single-port SRAM.
REQ-015 The block SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, ACCESS, DONE.
REQ-017 In IDLE with no request, the FSM SHALL stay in IDLE with sram_we=sram_oe=0.
REQ-018 In IDLE with any request, the FSM SHALL grant one requester per REQ-030, latch address, wdata and direction, load the wait counter with WAIT_CYCLES-1, and enter ACCESS next cycle.
REQ-019 In ACCESS, sram_addr/sram_wdata SHALL hold the latched values; sram_oe=1 for reads, sram_we=1 for writes, never both.
REQ-020 ACCESS SHALL last exactly WAIT_CYCLES cycles; on the last one (counter 0) a read SHALL capture sram_rdata into the granted port's rdata register, then the FSM SHALL enter DONE.
REQ-021 In DONE, exactly the granted port's ready SHALL be 1 for that one cycle; the FSM SHALL then return to IDLE.
REQ-022 Latency: request sampled in IDLE at edge N -> ready high in cycle N+WAIT_CYCLES+1; a request arriving in ACCESS or DONE SHALL wait and be arbitrated in the next IDLE.
REQ-023 Requesters SHALL hold request and operands until ready; inputs changing during ACCESS SHALL NOT affect the in-flight access.
REQ-024 A request dropped mid-access SHALL NOT abort it; ready still pulses.
REQ-025 mem_rd and mem_wr both high SHALL be treated as a write.
REQ-026 if_rdata and mem_rdata SHALL hold their last captured value until the next read completes on that port; writes SHALL leave mem_rdata unchanged.
REQ-027 Only one requester SHALL be granted per access; the loser waits without being dropped.

Reset
REQ-028 On rst at a clock edge the FSM SHALL go to IDLE, aborting any access; the next cycle SHALL show sram_we=sram_oe=0, busy=0, both ready=0.
REQ-029 Reset SHALL clear if_rdata, mem_rdata, sram_addr, sram_wdata, wait counter and round-robin pointer to 0.

Configuration
REQ-030 Macro ARB_ROUND_ROBIN_EN: when defined, simultaneous requests in IDLE SHALL be granted to the port not served by the previous access (pointer reset to "fetch last", so data wins first); when undefined, data (mem_rd/mem_wr) SHALL always beat fetch.

Verification
REQ-031 WAIT_CYCLES=3, if_req=1, if_addr=0x10, sram_rdata=0xE3A01005 -> sram_oe high 3 cycles, if_ready pulse in cycle 4, if_rdata=0xE3A01005.
REQ-032 mem_wr=1, mem_addr=0x400, mem_wdata=0xDEADBEEF -> sram_we high 3 cycles with those values, sram_oe=0, mem_ready pulse in cycle 4, mem_rdata unchanged.
REQ-033 if_req and mem_rd both held continuously, without macro -> three consecutive grants all data, no if_ready; with macro -> grants alternate data, fetch, data.
REQ-034 rst asserted in second ACCESS cycle of a write -> next cycle sram_we=0, busy=0, no mem_ready pulse, rdata registers 0.
REQ-035 WAIT_CYCLES=1, mem_rd=mem_wr=1 -> single-cycle sram_we, mem_ready two cycles after request sampled, no sram_oe.
